// File: rtl/pipe_stage_buf.sv
// Generic inter-stage pipeline register: valid/ready handshake, 2-entry skid
// buffer, flush with NOP insertion and a saturating stall counter (falling-edge state).
module pipe_stage_buf #(
   parameter int                WIDTH     = 64,
   parameter logic [WIDTH-1:0]  NOP_VALUE = {WIDTH{1'b0}},
   parameter int                CNT_W     = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cycles
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] STALL_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  m_q, m_d;
   logic [WIDTH-1:0]  s_q, s_d;
   logic [CNT_W-1:0]  stall_q, stall_d;
   logic              push_s;
   logic              pop_s;

   // Handshake outputs depend on registered state only, so backpressure never ripples.
   always_comb begin
      in_ready     = 1'b1;
      out_valid    = 1'b0;
      out_data     = NOP_VALUE;
      occupancy    = 2'd0;
      stall_cycles = stall_q;
      in_ready     = (state_q != FULL);
      out_valid    = (state_q != EMPTY);
      occupancy    = state_q;
      if (out_valid) begin
         out_data = m_q;
      end else begin
         out_data = NOP_VALUE;
      end
   end

   assign push_s = in_valid & in_ready;
   assign pop_s  = out_valid & out_ready;

   // Next-state for the storage FSM; flush beats any push/pop on the same edge.
   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      s_d     = s_q;
      if (flush) begin
         state_d = EMPTY;
         m_d     = NOP_VALUE;
         s_d     = NOP_VALUE;
      end else begin
         case (state_q)
            EMPTY: begin
               if (push_s) begin
                  m_d     = in_data;
                  state_d = ONE;
               end else begin
                  state_d = EMPTY;
               end
            end
            ONE: begin
               if (push_s && pop_s) begin
                  m_d     = in_data;
                  state_d = ONE;
               end else if (push_s) begin
                  s_d     = in_data;
                  state_d = FULL;
               end else if (pop_s) begin
                  // M keeps its stale word; out_data masks it while EMPTY.
                  state_d = EMPTY;
               end else begin
                  state_d = ONE;
               end
            end
            FULL: begin
               if (pop_s) begin
                  m_d     = s_q;
                  state_d = ONE;
               end else begin
                  state_d = FULL;
               end
            end
            default: begin
               state_d = EMPTY;
               m_d     = NOP_VALUE;
               s_d     = NOP_VALUE;
            end
         endcase
      end
   end

   // Stall counter counts held-but-not-taken edges and sticks at its maximum.
   always_comb begin
      stall_d = stall_q;
      if (out_valid && !out_ready && (stall_q != STALL_MAX)) begin
         stall_d = stall_q + STALL_ONE;
      end else begin
         stall_d = stall_q;
      end
   end

   // State registers; updates happen on the falling edge of CLK.
   always_ff @(negedge CLK) begin
      if (RST) begin
         state_q <= EMPTY;
         m_q     <= NOP_VALUE;
         s_q     <= NOP_VALUE;
         stall_q <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         s_q     <= s_d;
         stall_q <= stall_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed scoreboard bench for pipe_stage_buf: expected words are queued on
// push and compared on pop; a second CNT_W=4 instance checks saturation.
module tb_pipe_stage_buf;

   localparam logic [63:0] NOP = 64'h0000_0000_0000_0013;

   logic        CLK;
   logic        RST;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic [1:0]  occupancy;
   logic [15:0] stall_cycles;

   logic        s_rst;
   logic        s_in_valid;
   logic        s_in_ready;
   logic [63:0] s_in_data;
   logic        s_flush;
   logic        s_out_valid;
   logic        s_out_ready;
   logic [63:0] s_out_data;
   logic [1:0]  s_occupancy;
   logic [3:0]  s_stall;

   int          checks;
   int          errors;
   logic [63:0] exp_q[$];
   logic [15:0] exp_stall;

   pipe_stage_buf #(.WIDTH(64), .NOP_VALUE(NOP), .CNT_W(16)) dut (
      .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .occupancy(occupancy),
      .stall_cycles(stall_cycles)
   );

   pipe_stage_buf #(.WIDTH(64), .NOP_VALUE(NOP), .CNT_W(4)) dut_sat (
      .CLK(CLK), .RST(s_rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_data(s_in_data), .flush(s_flush), .out_valid(s_out_valid),
      .out_ready(s_out_ready), .out_data(s_out_data), .occupancy(s_occupancy),
      .stall_cycles(s_stall)
   );

   initial begin
      CLK = 1'b1;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One falling edge: check pre-edge outputs against the model, then advance model.
   task automatic cycle(input logic iv, input logic [63:0] d, input logic ordy, input logic fl);
      int   n;
      logic push;
      logic pop;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      n = exp_q.size();
      chk("in_ready", {63'd0, in_ready}, {63'd0, (n != 2)});
      chk("out_valid", {63'd0, out_valid}, {63'd0, (n != 0)});
      chk("occupancy", {62'd0, occupancy}, 64'(n));
      chk("stall_cycles", {48'd0, stall_cycles}, {48'd0, exp_stall});
      if (n == 0) chk("out_data_nop", out_data, NOP);
      else        chk("out_data", out_data, exp_q[0]);
      push = iv && (n != 2);
      pop  = (n != 0) && ordy;
      if ((n != 0) && !ordy && (exp_stall != 16'hFFFF)) exp_stall = exp_stall + 16'd1;
      if (pop) void'(exp_q.pop_front());
      if (fl) exp_q.delete();
      else if (push) exp_q.push_back(d);
      @(negedge CLK);
      @(posedge CLK);
   endtask

   task automatic do_reset(input logic iv, input logic [63:0] d);
      RST = 1'b1;
      in_valid = iv;
      in_data = d;
      @(negedge CLK);
      @(posedge CLK);
      RST = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      exp_stall = 16'd0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      exp_stall = 16'd0;
      RST = 1'b0;
      in_valid = 1'b0;
      in_data = 64'hx;
      flush = 1'b0;
      out_ready = 1'b0;
      s_rst = 1'b1;
      s_in_valid = 1'b0;
      s_in_data = 64'd0;
      s_flush = 1'b0;
      s_out_ready = 1'b0;

      do_reset(1'b0, 64'hx);
      s_rst = 1'b0;

      // Stream 1..4 with out_ready high, X on idle data
      cycle(1'b0, 64'hx, 1'b1, 1'b0);
      for (int i = 1; i <= 4; i++) cycle(1'b1, 64'(i), 1'b1, 1'b0);
      cycle(1'b0, 64'hx, 1'b1, 1'b0);
      cycle(1'b0, 64'hx, 1'b1, 1'b0);

      // Backpressure fill, held C has no effect, then drain in order
      cycle(1'b1, 64'hA, 1'b0, 1'b0);
      cycle(1'b1, 64'hB, 1'b0, 1'b0);
      cycle(1'b1, 64'hC, 1'b0, 1'b0);
      cycle(1'b1, 64'hC, 1'b0, 1'b0);
      cycle(1'b1, 64'hC, 1'b1, 1'b0);
      cycle(1'b1, 64'hC, 1'b1, 1'b0);
      cycle(1'b0, 64'hx, 1'b1, 1'b0);
      cycle(1'b0, 64'hx, 1'b1, 1'b0);

      // Simultaneous push/pop at ONE
      cycle(1'b1, 64'd5, 1'b0, 1'b0);
      cycle(1'b1, 64'd6, 1'b1, 1'b0);
      cycle(1'b0, 64'hx, 1'b1, 1'b0);
      cycle(1'b0, 64'hx, 1'b0, 1'b0);

      // Flush while FULL with a concurrent push that must vanish
      cycle(1'b1, 64'h10, 1'b0, 1'b0);
      cycle(1'b1, 64'h11, 1'b0, 1'b0);
      cycle(1'b1, 64'hDEAD, 1'b0, 1'b1);
      chk("flush_nop", out_data, NOP);
      cycle(1'b1, 64'h20, 1'b1, 1'b0);
      cycle(1'b0, 64'hx, 1'b1, 1'b0);
      cycle(1'b0, 64'hx, 1'b1, 1'b0);

      // Reset mid-operation with FULL and stall_cycles at 7
      cycle(1'b1, 64'h30, 1'b0, 1'b0);
      cycle(1'b1, 64'h31, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         if (exp_stall < 16'd7) cycle(1'b0, 64'hx, 1'b0, 1'b0);
      end
      chk("stall_7", {48'd0, stall_cycles}, 64'd7);
      chk("full_occ", {62'd0, occupancy}, 64'd2);
      do_reset(1'b1, 64'h99);
      cycle(1'b0, 64'hx, 1'b0, 1'b0);
      cycle(1'b1, 64'h40, 1'b1, 1'b0);
      cycle(1'b0, 64'hx, 1'b1, 1'b0);

      // Saturation on the CNT_W=4 instance
      s_in_valid = 1'b1;
      s_in_data = 64'h7;
      s_out_ready = 1'b0;
      @(negedge CLK);
      @(posedge CLK);
      s_in_valid = 1'b0;
      chk("sat_start", {60'd0, s_stall}, 64'd0);
      repeat (10) begin @(negedge CLK); @(posedge CLK); end
      chk("sat_10", {60'd0, s_stall}, 64'd10);
      repeat (10) begin @(negedge CLK); @(posedge CLK); end
      chk("sat_20", {60'd0, s_stall}, 64'd15);
      repeat (5) begin @(negedge CLK); @(posedge CLK); end
      chk("sat_hold", {60'd0, s_stall}, 64'd15);
      chk("sat_data", s_out_data, 64'h7);
      chk("sat_occ", {62'd0, s_occupancy}, 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed-width IF/ID latch. A generic inter-stage pipeline register with a valid/ready handshake, a 2-entry skid buffer, flush with bubble (NOP) insertion, and a saturating stall counter.
- Sits between any two pipeline stages, e.g. IF→ID with {pc4, IR} packed into DATA.
- Sustains one transfer per cycle.
- Backpressure does not ripple combinationally, because in_ready is registered.

Parameters:
- WIDTH, 64: payload width in bits (default holds {pc4[31:0], IR[31:0]}).
- NOP_VALUE, 64'h0: value presented on out_data when no valid entry, and loaded into storage on reset/flush.
- CNT_W, 16: width of the stall counter.

Ports:
- CLK  in  1  clock; all state updates on the falling edge (pipeline convention).
- RST  in  1  synchronous active-high reset, sampled on the falling edge of CLK.
- in_valid  in  1  upstream presents in_data.
- in_ready  out  1  buffer can accept; a function of registered state only.
- in_data  in  WIDTH  upstream payload.
- flush  in  1  discard all held and incoming entries this edge.
- out_valid  out  1  out_data holds a valid entry.
- out_ready  in  1  downstream accepts out_data this edge.
- out_data  out  WIDTH  head entry, or NOP_VALUE when out_valid=0.
- occupancy  out  2  entries held (0..2).
- stall_cycles  out  CNT_W  edges with out_valid=1 and out_ready=0; saturates.

Behaviour:
- Storage: head register M, skid register S, state count c ∈ {EMPTY=0, ONE=1, FULL=2}.
- push = in_valid & in_ready. pop = out_valid & out_ready. Both are evaluated at the falling edge.
- Combinational outputs from state:
  - in_ready = (c != FULL)
  - out_valid = (c != EMPTY)
  - out_data = out_valid ? M : NOP_VALUE
  - occupancy = c
- Priority at each edge: RST > flush > normal transitions.
- RST: c←EMPTY, M←NOP_VALUE, S←NOP_VALUE, stall_cycles←0.
  - Any concurrent push is discarded.
  - Reset mid-transfer loses all entries; no partial state is retained.
- Reset values of outputs: in_ready=1, out_valid=0, out_data=NOP_VALUE, occupancy=0, stall_cycles=0.
- flush (RST=0): c←EMPTY, M←NOP_VALUE, S←NOP_VALUE.
  - A push in the same edge is consumed from the upstream's point of view (in_ready was 1) but dropped.
  - A pop in the same edge completes downstream, then is gone.
  - stall_cycles is not cleared by flush.
- Normal transitions:
  - EMPTY: push → M←in_data, ONE. Otherwise hold.
  - ONE, push & pop → M←in_data, stay ONE.
  - ONE, push & !pop → S←in_data, go FULL.
  - ONE, !push & pop → EMPTY; M keeps its stale value but is masked to NOP_VALUE on out_data.
  - ONE, neither → hold.
  - FULL: push is impossible because in_ready=0.
  - FULL, pop → M←S, go ONE. Otherwise hold.
- Ordering: strict FIFO; S is always younger than M.
- Latency: data pushed at edge k appears on out_data after edge k (one edge), when the buffer was EMPTY or popped at k.
- Throughput: with out_ready held at 1 the buffer stays at ≤ ONE and passes one word per edge.
- stall_cycles: increments by 1 at each edge where out_valid=1 and out_ready=0. Holds at 2^CNT_W−1 and does not wrap.
- in_valid with in_ready=0 has no effect; the upstream must hold its data.
- X on in_data while in_valid=0 must never reach out_data.

Test Plan:
- Reset then stream: RST 1 edge, then in_valid=1 with data 1,2,3,4 on consecutive edges, out_ready=1 → out_data 1,2,3,4 one edge after each push; occupancy ≤1; stall_cycles=0.
- Backpressure fill: push A, B with out_ready=0 → occupancy=2, in_ready=0, stall_cycles=1 then 2. Holding in_valid with C changes nothing. Raise out_ready → out A, then B, then C, in order.
- Simultaneous push/pop at ONE: M=5, push 6 with out_ready=1 → out_data=6 next edge, occupancy stays 1.
- Flush while FULL with concurrent push: occupancy=2, flush=1, in_valid=1 → next edge occupancy=0, out_valid=0, out_data=NOP_VALUE; the pushed word never appears.
- Reset mid-operation: FULL with stall_cycles=7, assert RST → all outputs at reset values, including stall_cycles=0 and in_ready=1.
- Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 edges → stall_cycles=15 and holds.
